// File: rtl/param_memory_pkg.sv
// Shared types and default sizing for the parameterised memory with clear sweep.
package param_memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NTAPS = 3;

endpackage

// File: rtl/param_memory_init.sv
// Clear-sweep sequencer: walks every word address once after reset, then
// settles in READY.
module param_memory_init
  import param_memory_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] sweep_addr_o,
  output logic              sweep_we_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that existed before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_q <= READY;
      end
    end
  end

  // Decoded straight from the state register, so Busy is glitch-free.
  assign busy_o       = (state_q == INIT);
  assign sweep_addr_o = cnt_q;
  assign sweep_we_o   = (state_q == INIT) && !rst_i;

endmodule

// File: rtl/param_memory.sv
// Single-port word memory with a post-reset clear sweep, registered read
// port, out-of-range error pulse and a combinational view of the low words.
module param_memory
  import param_memory_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NTAPS  = DEF_NTAPS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   Write,
  input  logic [ADDR_W-1:0]      Address,
  input  logic [WIDTH-1:0]       DataIn,
  output logic [WIDTH-1:0]       DataOut,
  output logic                   ReadValid,
  output logic                   AddrErr,
  output logic                   Busy,
  output logic [NTAPS*WIDTH-1:0] Taps
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  logic              in_range;
  logic              req_ok;
  logic              do_write;

  logic [WIDTH-1:0]  data_d, data_q;
  logic              rvalid_d, rvalid_q;
  logic              err_d, err_q;

  param_memory_init #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init (
    .clk_i        (clock),
    .rst_i        (reset),
    .busy_o       (Busy),
    .sweep_addr_o (sweep_addr),
    .sweep_we_o   (sweep_we)
  );

  // One extra bit keeps the compare meaningful when DEPTH is a power of two.
  assign in_range = {1'b0, Address} < (ADDR_W + 1)'(DEPTH);
  assign req_ok   = enable && !Busy && !reset;
  assign do_write = req_ok && Write && in_range;

  // NOTE: the array has no reset branch; it is zeroed by the sweep instead,
  // which keeps it mappable onto plain RAM without a reset port.
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else if (do_write) begin
      mem_q[Address] <= DataIn;
    end
  end

  // NOTE: every variable driven here gets a default first, so no latch forms.
  always_comb begin
    data_d   = data_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (req_ok) begin
      if (!in_range) begin
        err_d = 1'b1;
        if (!Write) begin
          data_d   = '0;
          rvalid_d = 1'b1;
        end
      end else if (!Write) begin
        data_d   = mem_q[Address];
        rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign DataOut   = data_q;
  assign ReadValid = rvalid_q;
  assign AddrErr   = err_q;

  always_comb begin
    Taps = '0;
    for (int i = 0; i < NTAPS; i++) begin
      Taps[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench for param_memory: a default instance (DEPTH=8) and a
// non-power-of-two instance (DEPTH=6) driven side by side against a word-array model.
module tb_param_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        en   [2];
  logic        wr   [2];
  logic [2:0]  addr [2];
  logic [7:0]  din  [2];
  logic [7:0]  dout [2];
  logic        rv   [2];
  logic        err  [2];
  logic        busy [2];
  logic [23:0] taps [2];

  always #5 clk = ~clk;

  param_memory u_dut8 (
    .clock     (clk),
    .reset     (rst),
    .enable    (en[0]),
    .Write     (wr[0]),
    .Address   (addr[0]),
    .DataIn    (din[0]),
    .DataOut   (dout[0]),
    .ReadValid (rv[0]),
    .AddrErr   (err[0]),
    .Busy      (busy[0]),
    .Taps      (taps[0])
  );

  param_memory #(.DEPTH(6), .ADDR_W(3)) u_dut6 (
    .clock     (clk),
    .reset     (rst),
    .enable    (en[1]),
    .Write     (wr[1]),
    .Address   (addr[1]),
    .DataIn    (din[1]),
    .DataOut   (dout[1]),
    .ReadValid (rv[1]),
    .AddrErr   (err[1]),
    .Busy      (busy[1]),
    .Taps      (taps[1])
  );

  typedef struct {
    logic [7:0] data;
    bit         rv;
    bit         err;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit run_on   = 0;

  // Reference model: word array per instance, sweep countdown, expected DataOut.
  int         depth [2] = '{8, 6};
  logic [7:0] mdl_mem [2][8];
  int         busy_left [2];
  logic [7:0] exp_dout [2];

  bit         s_rst;
  bit         s_en   [2];
  bit         s_wr   [2];
  int         s_addr [2];
  logic [7:0] s_din  [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int id);
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t qpop(input int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qpush(input int id, input exp_t e);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Effect of the upcoming rising edge on the model of instance id.
  task automatic model_edge(input int id);
    exp_t e;
    if (s_rst) begin
      busy_left[id] = depth[id];
      exp_dout[id]  = 8'h00;
      return;
    end
    if (busy_left[id] > 0) begin
      busy_left[id]--;
      if (busy_left[id] == 0)
        for (int i = 0; i < 8; i++) mdl_mem[id][i] = 8'h00;
      return;
    end
    if (!s_en[id]) return;
    e.cyc  = cyc + 1;
    e.data = 8'h00;
    e.rv   = 1'b0;
    e.err  = 1'b0;
    if (s_addr[id] >= depth[id]) begin
      e.err = 1'b1;
      if (!s_wr[id]) begin
        e.rv = 1'b1;
        exp_dout[id] = 8'h00;
      end
      qpush(id, e);
    end else if (s_wr[id]) begin
      mdl_mem[id][s_addr[id]] = s_din[id];
    end else begin
      e.rv   = 1'b1;
      e.data = mdl_mem[id][s_addr[id]];
      exp_dout[id] = e.data;
      qpush(id, e);
    end
  endtask

  task automatic check_state();
    for (int id = 0; id < 2; id++) begin
      check($sformatf("busy%0d", id), busy[id], busy_left[id] > 0);
      check($sformatf("dataout_hold%0d", id), dout[id], exp_dout[id]);
      if (busy_left[id] == 0)
        check($sformatf("taps%0d", id), taps[id],
              {mdl_mem[id][2], mdl_mem[id][1], mdl_mem[id][0]});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (run_on) check_state();
    rst = s_rst;
    for (int id = 0; id < 2; id++) begin
      en[id]   = s_en[id];
      wr[id]   = s_wr[id];
      addr[id] = 3'(s_addr[id]);
      din[id]  = s_din[id];
    end
    model_edge(0);
    model_edge(1);
    for (int id = 0; id < 2; id++) s_en[id] = 1'b0;
    run_on = 1'b1;
  endtask

  task automatic set_req(input int id, input bit e, input bit w, input int a, input logic [7:0] d);
    s_en[id]   = e;
    s_wr[id]   = w;
    s_addr[id] = a;
    s_din[id]  = d;
  endtask

  task automatic both(input bit w, input int a, input logic [7:0] d);
    set_req(0, 1'b1, w, a, d);
    set_req(1, 1'b1, w, a, d);
    tick();
  endtask

  task automatic rand_tick();
    for (int id = 0; id < 2; id++)
      set_req(id, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), 8'($urandom));
    tick();
  endtask

  task automatic mon(input int id);
    exp_t e;
    bit   seen;
    seen = (rv[id] === 1'b1) || (err[id] === 1'b1);
    while (qsize(id) > 0 && qfront(id).cyc < cyc) begin
      e = qpop(id);
      check($sformatf("missing_resp%0d", id), 32'(seen), 32'd1);
    end
    if (seen) begin
      if (qsize(id) == 0) begin
        check($sformatf("unexpected_resp%0d", id), {30'd0, rv[id], err[id]}, 32'd0);
      end else begin
        e = qpop(id);
        check($sformatf("resp_cycle%0d", id), cyc, e.cyc);
        check($sformatf("read_valid%0d", id), rv[id], e.rv);
        check($sformatf("addr_err%0d", id), err[id], e.err);
        if (e.rv) check($sformatf("read_data%0d", id), dout[id], e.data);
      end
    end
  endtask

  always @(negedge clk) if (run_on) mon(0);
  always @(negedge clk) if (run_on) mon(1);

  initial begin
    rst = 1'b1;
    for (int id = 0; id < 2; id++) begin
      en[id] = 1'b0; wr[id] = 1'b0; addr[id] = 3'd0; din[id] = 8'h00;
      set_req(id, 1'b0, 1'b0, 0, 8'h00);
    end

    // Reset for one cycle, then requests during the sweep must be ignored.
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    both(1'b1, 2, 8'hFF);
    both(1'b0, 2, 8'h00);
    repeat (6) tick();

    // Directed: sweep result, write-then-read, hold with enable low.
    both(1'b0, 2, 8'h00);
    both(1'b1, 0, 8'h08);
    both(1'b0, 0, 8'h00);
    set_req(0, 1'b1, 1'b1, 7, 8'hA5); tick();
    set_req(0, 1'b1, 1'b0, 7, 8'h00); tick();
    repeat (3) tick();

    // Out-of-range accesses on the six-word instance.
    set_req(1, 1'b1, 1'b0, 6, 8'h00); tick();
    set_req(1, 1'b1, 1'b1, 7, 8'h11); tick();
    set_req(1, 1'b1, 1'b1, 1, 8'h3C); tick();
    set_req(1, 1'b1, 1'b0, 1, 8'h00); tick();

    repeat (400) rand_tick();

    // Reset in READY, then again four cycles into the sweep.
    s_rst = 1'b1; tick();
    s_rst = 1'b0;
    repeat (4) rand_tick();
    s_rst = 1'b1; tick();
    s_rst = 1'b0;
    repeat (8) rand_tick();
    for (int a = 0; a < 8; a++) both(1'b0, a, 8'h00);

    repeat (200) rand_tick();
    repeat (3) tick();

    check("scoreboard_empty0", q0.size(), 0);
    check("scoreboard_empty1", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of words (2..256).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter NTAPS, default 3, number of low words exposed as taps (1..DEPTH).
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  request strobe, sampled each rising edge.
REQ-008 SHALL have port Write  input  1  1 = write request, 0 = read request.
REQ-009 SHALL have port Address  input  ADDR_W  word address.
REQ-010 SHALL have port DataIn  input  WIDTH  write data.
REQ-011 SHALL have port DataOut  output  WIDTH  registered read data.
REQ-012 SHALL have port ReadValid  output  1  one-cycle pulse marking new DataOut.
REQ-013 SHALL have port AddrErr  output  1  one-cycle pulse on an out-of-range access.
REQ-014 SHALL have port Busy  output  1  high while the clear sweep runs; requests are ignored.
REQ-015 SHALL have port Taps  output  NTAPS*WIDTH  mem[i] on bits [i*WIDTH +: WIDTH].

Function
REQ-016 SHALL implement a two-state FSM: INIT (clear sweep) and READY.
REQ-017 In INIT, each cycle SHALL write 0 to mem[sweep_cnt] and increment sweep_cnt; after writing DEPTH-1 it SHALL enter READY, so INIT lasts exactly DEPTH cycles.
REQ-018 Busy SHALL be 1 in INIT and 0 in READY.
REQ-019 In INIT, enable SHALL be ignored: no write, ReadValid=0, AddrErr=0, DataOut held.
REQ-020 In READY, with enable=1 and Write=1 and Address<DEPTH, mem[Address] SHALL take DataIn at the edge; ReadValid=0; DataOut held.
REQ-021 In READY, with enable=1 and Write=0 and Address<DEPTH, DataOut SHALL take mem[Address] at the edge, and ReadValid SHALL be 1 for that one cycle (latency 1).
REQ-022 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-023 With enable=0, ReadValid and AddrErr SHALL be 0 and DataOut SHALL hold.
REQ-024 An access with Address>=DEPTH SHALL pulse AddrErr for one cycle; a write SHALL be dropped; a read SHALL load DataOut=0 with ReadValid=1.
REQ-025 Taps SHALL be a combinational view of the array and SHALL reflect a write from the following cycle onward.
REQ-026 Back-to-back requests on consecutive cycles SHALL be serviced without stalls.

Reset
REQ-027 On reset=1 at an edge: state=INIT, sweep_cnt=0, DataOut=0, ReadValid=0, AddrErr=0, Busy=1.
REQ-028 Array contents SHALL be cleared only by the sweep, not by reset directly; Taps are all zero once Busy falls.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep from word 0; reset in READY SHALL re-enter INIT.

Structure
REQ-030 Package param_memory_pkg SHALL hold the state enum (INIT, READY) and the default WIDTH/DEPTH/NTAPS constants.
REQ-031 The sweep counter and FSM SHALL be a sub-module param_memory_init that outputs Busy, the sweep address and the sweep write enable; the array and read path SHALL stay in param_memory.

Verification (defaults unless stated)
REQ-032 Reset 1 cycle, then release -> Busy=1 for 8 cycles, then 0; DataOut=0; Taps=24'h000000.
REQ-033 Write 8'h08 to addr 0, then read addr 0 -> DataOut=8'h08 one cycle later, ReadValid high 1 cycle; Taps[7:0]=8'h08.
REQ-034 Write 8'hFF to addr 2 while Busy, then read addr 2 after READY -> DataOut=8'h00.
REQ-035 Write 8'hA5 to addr 7, read addr 7, then enable=0 for 3 cycles -> DataOut holds 8'hA5, ReadValid=0.
REQ-036 Reset re-asserted on sweep cycle 4 after prior writes -> Busy for a full 8 cycles after release; all words read 0.
REQ-037 DEPTH=6, ADDR_W=3: read addr 6 -> DataOut=0, ReadValid=1, AddrErr pulse; write 8'h11 to addr 7 -> AddrErr pulse, no array change.
